// File: rtl/io_write_buffer.sv
// Snooping write buffer between the CPU bus and a UART host buffer: queues bytes written to
// the IO port, drains them whenever downstream has room, and tracks program-stop completion.
module io_write_buffer #(
  parameter int DEPTH_LOG = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [31:0]          mem_a,
  input  logic [7:0]           mem_dout,
  input  logic                 mem_wr,
  input  logic                 hci_full,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  output logic                 io_buffer_full,
  output logic                 prog_done,
  output logic                 overflow,
  output logic [DEPTH_LOG:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   AF_CNT    = (DEPTH_LOG + 1)'(AF_MARGIN);
  localparam logic [DEPTH_LOG:0]   CNT_ONE   = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE   = DEPTH_LOG'(1);

  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 stop_pending;

  logic                 io_sel;
  logic                 enq_req;
  logic                 stop_req;
  logic                 deq;
  logic                 full;
  logic                 enq;
  logic                 drop;
  logic [DEPTH_LOG:0]   free_slots;

  // Only the port-select and register-offset bits of the address are decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3]};

  // NOTE: every signal gets a value at the top of always_comb so no path can infer a latch.
  always_comb begin
    io_sel     = rdy_in & mem_wr & (mem_a[17:16] == 2'b11);
    enq_req    = io_sel & (mem_a[2:0] == 3'b000) & (mem_dout != 8'h00) & ~stop_pending;
    stop_req   = io_sel & (mem_a[2:0] == 3'b100);
    deq        = rdy_in & ~hci_full & (count != '0);
    full       = (count == DEPTH_CNT);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    enq        = enq_req & (~full | deq);
    drop       = enq_req & full & ~deq;
    free_slots = DEPTH_CNT - count;
    io_buffer_full = (free_slots <= AF_CNT);
  end

  // NOTE: the storage array has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (enq && !rst_in) begin
      mem[wr_ptr] <= mem_dout;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stop_pending <= 1'b0;
      prog_done    <= 1'b0;
      overflow     <= 1'b0;
      tx_en        <= 1'b0;
      tx_data      <= 8'h00;
    end else if (rdy_in) begin
      tx_en <= deq;
      if (deq) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      if (stop_req) begin
        stop_pending <= 1'b1;
      end
      // An empty FIFO means the final byte's dequeue edge has already passed.
      if (stop_pending && (count == '0)) begin
        prog_done <= 1'b1;
      end
    end else begin
      tx_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_write_buffer.sv
// Self-checking bench for io_write_buffer: directed scenarios plus randomized bus traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_io_write_buffer;

  localparam int DEPTH_LOG = 4;
  localparam int DEPTH     = 1 << DEPTH_LOG;
  localparam int AF_MARGIN = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 rdy_in;
  logic [31:0]          mem_a;
  logic [7:0]           mem_dout;
  logic                 mem_wr;
  logic                 hci_full;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 io_buffer_full;
  logic                 prog_done;
  logic                 overflow;
  logic [DEPTH_LOG:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  io_write_buffer #(.DEPTH_LOG(DEPTH_LOG), .AF_MARGIN(AF_MARGIN)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .hci_full       (hci_full),
    .tx_en          (tx_en),
    .tx_data        (tx_data),
    .io_buffer_full (io_buffer_full),
    .prog_done      (prog_done),
    .overflow       (overflow),
    .count          (count)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: a byte queue plus the sticky flags, advanced once per clock edge.
  logic [7:0] mq[$];
  bit         m_stop;
  bit         m_done;
  bit         m_ovf;
  bit         m_tx_en;
  logic [7:0] m_tx_data;

  function automatic void model_step();
    bit io;
    bit pop;
    int size_before;
    if (rst_in) begin
      mq.delete();
      m_stop = 0; m_done = 0; m_ovf = 0; m_tx_en = 0; m_tx_data = 8'h00;
      return;
    end
    if (!rdy_in) begin
      m_tx_en = 0;
      return;
    end
    io          = mem_wr && (mem_a[17:16] == 2'b11);
    size_before = mq.size();
    pop         = !hci_full && (size_before > 0);
    m_tx_en     = pop;
    if (pop) m_tx_data = mq.pop_front();
    if (io && mem_a[2:0] == 3'b000 && mem_dout != 8'h00 && !m_stop) begin
      if (mq.size() < DEPTH) mq.push_back(mem_dout);
      else m_ovf = 1;
    end
    if (m_stop && size_before == 0) m_done = 1;
    if (io && mem_a[2:0] == 3'b100) m_stop = 1;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr = wr; mem_a = a; mem_dout = d;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; hci_full = 1'b0;
    bus(1'b0, 32'h0, 8'h00);
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; hci_full = 1'b0;
    bus(1'b1, 32'h0003_0000, 8'h77);
    tick(); tick();
    n_cmp += 6;
    if (count !== '0)       begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
    if (tx_en !== 1'b0)     begin n_bad++; $display("FAIL rst_tx_en: got %b want 0", tx_en); end
    if (tx_data !== 8'h00)  begin n_bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    if (prog_done !== 1'b0) begin n_bad++; $display("FAIL rst_prog_done: got %b want 0", prog_done); end
    if (overflow !== 1'b0)  begin n_bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL rst_af: got %b want 0", io_buffer_full); end
    rst_in = 1'b0;
    hci_full = 1'b1;
    bus(1'b1, 32'h0003_0000, 8'h5A);
    tick();
    bus(1'b0, 32'h0, 8'h00);
    n_cmp++;
    if (count !== 5'd1) begin n_bad++; $display("FAIL first_enq_after_rst: count got %0d want 1", count); end
  endtask

  task automatic test_abc();
    logic exp_en;
    logic [7:0] exp_d;
    do_reset();
    for (int t = 0; t < 7; t++) begin
      if (t < 3) bus(1'b1, 32'h0003_0000, 8'(8'h41 + t));
      else       bus(1'b0, 32'h0, 8'h00);
      tick();
      exp_en = (t + 1 >= 2) && (t + 1 <= 4);
      exp_d  = 8'(8'h41 + t - 1);
      n_cmp++;
      if (tx_en !== exp_en) begin n_bad++; $display("FAIL abc_tx_en cyc%0d: got %b want %b", t + 1, tx_en, exp_en); end
      if (exp_en) begin
        n_cmp++;
        if (tx_data !== exp_d) begin n_bad++; $display("FAIL abc_tx_data cyc%0d: got %h want %h", t + 1, tx_data, exp_d); end
      end
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int exp_cnt;
    int n_tx;
    do_reset();
    hci_full = 1'b1;
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom_range(1, 255));
      if (i < 16) exp_q.push_back(d);
      bus(1'b1, 32'h0003_0000, d);
      tick();
      exp_cnt = (i + 1 > 16) ? 16 : i + 1;
      n_cmp += 3;
      if (count !== 5'(exp_cnt)) begin n_bad++; $display("FAIL fill_count w%0d: got %0d want %0d", i, count, exp_cnt); end
      if (io_buffer_full !== (exp_cnt >= 14)) begin n_bad++; $display("FAIL fill_af w%0d: got %b want %b", i, io_buffer_full, exp_cnt >= 14); end
      if (overflow !== (i == 16)) begin n_bad++; $display("FAIL fill_ovf w%0d: got %b want %b", i, overflow, i == 16); end
    end
    bus(1'b0, 32'h0, 8'h00);
    hci_full = 1'b0;
    n_tx = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (tx_en === 1'b1) begin
        n_tx++;
        if (exp_q.size() > 0) begin
          d = exp_q.pop_front();
          n_cmp++;
          if (tx_data !== d) begin n_bad++; $display("FAIL fill_drain_data #%0d: got %h want %h", n_tx, tx_data, d); end
        end
      end
    end
    n_cmp += 2;
    if (n_tx != 16)     begin n_bad++; $display("FAIL fill_drain_n: got %0d want 16", n_tx); end
    if (count !== '0)   begin n_bad++; $display("FAIL fill_drain_count: got %0d want 0", count); end
  endtask

  task automatic test_ignored();
    logic        wr_t[3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] a_t[3]  = '{32'h0003_0000, 32'h0003_0000, 32'h0002_0000};
    logic [7:0]  d_t[3]  = '{8'h00, 8'h41, 8'h55};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) bus(wr_t[i], a_t[i], d_t[i]);
      else       bus(1'b0, 32'h0, 8'h00);
      tick();
      n_cmp += 3;
      if (count !== '0)      begin n_bad++; $display("FAIL ign_count s%0d: got %0d want 0", i, count); end
      if (tx_en !== 1'b0)    begin n_bad++; $display("FAIL ign_tx_en s%0d: got %b want 0", i, tx_en); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL ign_ovf s%0d: got %b want 0", i, overflow); end
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int n_tx;
    do_reset();
    hci_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(1, 255));
      exp_q.push_back(d);
      bus(1'b1, 32'h0003_0000, d);
      tick();
    end
    n_cmp++;
    if (count !== 5'd16) begin n_bad++; $display("FAIL simul_prefill: got %0d want 16", count); end
    hci_full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(1, 255));
      exp_q.push_back(d);
      bus(1'b1, 32'h0003_0000, d);
      tick();
      d = exp_q.pop_front();
      n_cmp += 3;
      if (count !== 5'd16) begin n_bad++; $display("FAIL simul_count i%0d: got %0d want 16", i, count); end
      if (tx_en !== 1'b1)  begin n_bad++; $display("FAIL simul_tx_en i%0d: got %b want 1", i, tx_en); end
      if (tx_data !== d)   begin n_bad++; $display("FAIL simul_data i%0d: got %h want %h", i, tx_data, d); end
    end
    bus(1'b0, 32'h0, 8'h00);
    n_tx = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_en === 1'b1 && exp_q.size() > 0) begin
        n_tx++;
        d = exp_q.pop_front();
        n_cmp++;
        if (tx_data !== d) begin n_bad++; $display("FAIL simul_drain #%0d: got %h want %h", n_tx, tx_data, d); end
      end
    end
    n_cmp += 2;
    if (n_tx != 16)        begin n_bad++; $display("FAIL simul_drain_n: got %0d want 16", n_tx); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL simul_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_stop();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int n_tx;
    int last_tx;
    int first_done;
    do_reset();
    hci_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(1, 255));
      exp_q.push_back(d);
      bus(1'b1, 32'h0003_0000, d);
      tick();
    end
    bus(1'b1, 32'h0003_0004, 8'h00); tick();
    bus(1'b1, 32'h0003_0000, 8'h41); tick();
    bus(1'b0, 32'h0, 8'h00); tick();
    n_cmp += 3;
    if (count !== 5'd3)     begin n_bad++; $display("FAIL stop_drop_count: got %0d want 3", count); end
    if (overflow !== 1'b0)  begin n_bad++; $display("FAIL stop_drop_ovf: got %b want 0", overflow); end
    if (prog_done !== 1'b0) begin n_bad++; $display("FAIL stop_early_done: got %b want 0", prog_done); end
    hci_full = 1'b0;
    n_tx = 0; last_tx = -1; first_done = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (tx_en === 1'b1) begin
        n_tx++;
        last_tx = c;
        if (exp_q.size() > 0) begin
          d = exp_q.pop_front();
          n_cmp++;
          if (tx_data !== d) begin n_bad++; $display("FAIL stop_data #%0d: got %h want %h", n_tx, tx_data, d); end
        end
      end
      if (prog_done === 1'b1 && first_done < 0) first_done = c;
    end
    n_cmp += 3;
    if (n_tx != 3) begin n_bad++; $display("FAIL stop_n_tx: got %0d want 3", n_tx); end
    if (first_done != last_tx + 1) begin n_bad++; $display("FAIL stop_done_cycle: got %0d want %0d", first_done, last_tx + 1); end
    if (prog_done !== 1'b1) begin n_bad++; $display("FAIL stop_done_sticky: got %b want 1", prog_done); end
  endtask

  task automatic test_stop_empty();
    do_reset();
    bus(1'b1, 32'h0003_0004, 8'h00); tick();
    bus(1'b0, 32'h0, 8'h00);
    n_cmp++;
    if (prog_done !== 1'b0) begin n_bad++; $display("FAIL stop_empty_c1: got %b want 0", prog_done); end
    tick();
    n_cmp++;
    if (prog_done !== 1'b1) begin n_bad++; $display("FAIL stop_empty_c2: got %b want 1", prog_done); end
  endtask

  task automatic test_rdy_freeze();
    logic [7:0] b[5];
    do_reset();
    hci_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom_range(1, 255));
      bus(1'b1, 32'h0003_0000, b[i]);
      tick();
    end
    bus(1'b0, 32'h0, 8'h00);
    hci_full = 1'b0;
    tick(); tick();
    n_cmp += 2;
    if (tx_data !== b[1]) begin n_bad++; $display("FAIL frz_pre_data: got %h want %h", tx_data, b[1]); end
    if (count !== 5'd3)   begin n_bad++; $display("FAIL frz_pre_count: got %0d want 3", count); end
    rdy_in = 1'b0;
    bus(1'b1, 32'h0003_0004, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp += 4;
      if (tx_en !== 1'b0)     begin n_bad++; $display("FAIL frz_tx_en c%0d: got %b want 0", i, tx_en); end
      if (count !== 5'd3)     begin n_bad++; $display("FAIL frz_count c%0d: got %0d want 3", i, count); end
      if (tx_data !== b[1])   begin n_bad++; $display("FAIL frz_data c%0d: got %h want %h", i, tx_data, b[1]); end
      if (prog_done !== 1'b0) begin n_bad++; $display("FAIL frz_done c%0d: got %b want 0", i, prog_done); end
    end
    rdy_in = 1'b1;
    bus(1'b0, 32'h0, 8'h00);
    tick();
    n_cmp += 2;
    if (tx_en !== 1'b1 || tx_data !== b[2]) begin n_bad++; $display("FAIL frz_resume: got %b/%h want 1/%h", tx_en, tx_data, b[2]); end
    if (count !== 5'd2) begin n_bad++; $display("FAIL frz_resume_count: got %0d want 2", count); end
    // Overfill to raise overflow, then drain down to 5 queued with a pulse in flight.
    do_reset();
    hci_full = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus(1'b1, 32'h0003_0000, 8'($urandom_range(1, 255)));
      tick();
    end
    bus(1'b0, 32'h0, 8'h00);
    hci_full = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    n_cmp += 2;
    if (count !== 5'd5 || tx_en !== 1'b1) begin n_bad++; $display("FAIL rst5_pre: got count %0d en %b want 5/1", count, tx_en); end
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL rst5_pre_ovf: got %b want 1", overflow); end
    rst_in = 1'b1;
    tick();
    n_cmp += 4;
    if (count !== '0)       begin n_bad++; $display("FAIL rst5_count: got %0d want 0", count); end
    if (tx_en !== 1'b0)     begin n_bad++; $display("FAIL rst5_tx_en: got %b want 0", tx_en); end
    if (prog_done !== 1'b0) begin n_bad++; $display("FAIL rst5_done: got %b want 0", prog_done); end
    if (overflow !== 1'b0)  begin n_bad++; $display("FAIL rst5_ovf: got %b want 0", overflow); end
    rst_in = 1'b0;
    tick(); tick();
    n_cmp++;
    if (tx_en !== 1'b0) begin n_bad++; $display("FAIL rst5_discard: got %b want 0", tx_en); end
  endtask

  task automatic test_random();
    logic [31:0] addrs[6] = '{32'h0003_0000, 32'h0003_0000, 32'h0003_0008, 32'h0002_0000,
                              32'h0001_0004, 32'h0003_0001};
    int pick;
    for (int pass = 0; pass < 3; pass++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        rst_in   = ($urandom_range(0, 299) == 0);
        rdy_in   = ($urandom_range(0, 9) != 0);
        hci_full = ($urandom_range(0, 9) < 3 + 3 * pass);
        pick     = $urandom_range(0, 5);
        if ($urandom_range(0, 249) == 0) bus(1'b1, 32'h0003_0004, 8'h00);
        else bus(($urandom_range(0, 3) != 0), addrs[pick],
                 ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
        tick();
        n_cmp += 6;
        if (tx_en !== m_tx_en) begin n_bad++; $display("FAIL rnd_tx_en p%0d c%0d: got %b want %b", pass, c, tx_en, m_tx_en); end
        if (tx_data !== m_tx_data) begin n_bad++; $display("FAIL rnd_tx_data p%0d c%0d: got %h want %h", pass, c, tx_data, m_tx_data); end
        if (count !== 5'(mq.size())) begin n_bad++; $display("FAIL rnd_count p%0d c%0d: got %0d want %0d", pass, c, count, mq.size()); end
        if (io_buffer_full !== ((DEPTH - mq.size()) <= AF_MARGIN)) begin n_bad++; $display("FAIL rnd_af p%0d c%0d: got %b", pass, c, io_buffer_full); end
        if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf p%0d c%0d: got %b want %b", pass, c, overflow, m_ovf); end
        if (prog_done !== m_done) begin n_bad++; $display("FAIL rnd_done p%0d c%0d: got %b want %b", pass, c, prog_done, m_done); end
      end
      rst_in = 1'b0;
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; hci_full = 1'b0;
    bus(1'b0, 32'h0, 8'h00);
    test_reset();
    test_abc();
    test_fill_overflow();
    test_ignored();
    test_full_simul();
    test_stop();
    test_stop_empty();
    test_rdy_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
